// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding 64-bit read or byte-masked write,
// answered LAT cycles after acceptance and held until the initiator takes it.
module dmem_responder #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
  localparam logic [63:0] DEPTH_W  = 64'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH];

  logic [63:0]   off;
  logic [AW-1:0] idx;
  logic          acc_err;
  logic          access;
  logic          mem_we;

  // Below-BASE addresses are flagged before the offset is used, so the
  // unsigned wrap of off in that case is harmless.
  assign off     = addr_q - BASE;
  assign idx     = off[AW+2:3];
  assign acc_err = (addr_q < BASE) | ((off >> 3) >= DEPTH_W) | (addr_q[2:0] != 3'd0);
  assign access  = (state_q == WAIT) && (cnt_q == 4'd0);
  assign mem_we  = access && wen_q && !acc_err;

  // A transfer happens on an edge where valid & ready are both high; valid
  // never waits on ready and, once raised by the responder, holds its payload.
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || wen_q) ? 64'd0 : mem_q[idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 64'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Store is deliberately not reset; the commit is gated by state_q, which
  // reset forces to IDLE, so a write caught in WAIT never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
